// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the main-memory arbiter.
package mem_arb_pkg;

  localparam int BLK_WORDS_DEF  = 8;
  localparam int WORD_BYTES_DEF = 2;
  localparam int IDX_W          = $clog2(BLK_WORDS_DEF);
  localparam int OFFSET_W       = $clog2(BLK_WORDS_DEF * WORD_BYTES_DEF);

  // Memory ownership state; also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: issues BLK_WORDS word reads and counts the returning
// words. It is shared by both fill states and is idle (counters held at zero)
// whenever active_i is low.
module mem_fill_seq #(
  parameter int BLK_WORDS  = 8,
  parameter int WORD_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         active_i,
  input  logic                         rvalid_i,
  output logic                         issue_en_o,
  output logic [15:0]                  offset_o,
  output logic                         recv_en_o,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx_o,
  output logic                         last_o
);

  localparam int IW = $clog2(BLK_WORDS);
  localparam int CW = IW + 1;

  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d;

  assign issue_en_o = active_i && (issue_cnt_q < CW'(BLK_WORDS));
  assign offset_o   = 16'(issue_cnt_q[IW-1:0]) * 16'(WORD_BYTES);
  // Returns outside a fill or past the last word are dropped here.
  assign recv_en_o  = active_i && rvalid_i && (recv_cnt_q < CW'(BLK_WORDS));
  assign fill_idx_o = recv_en_o ? recv_cnt_q[IW-1:0] : '0;
  assign last_o     = recv_en_o && (recv_cnt_q == CW'(BLK_WORDS - 1));

  // Counter next-state: advance on issue/receive, clear at end or when idle.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (!active_i || last_o) begin
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_en_o) issue_cnt_d = issue_cnt_q + CW'(1);
      if (recv_en_o)  recv_cnt_d  = recv_cnt_q + CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between the I-cache and D-cache miss handlers.
//
// Handshake: a side raises *_req and holds it, with stable command fields,
// until the cycle in which *_done pulses; it drops req at the clock edge that
// ends that cycle. Ownership is shown on *_grant (decoded from state). A req
// still high in the IDLE cycle after done counts as a new request. Memory
// commands are valid when mem_en=1 (no back-pressure); read data returns in
// order on mem_rvalid with a fixed latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLK_WORDS  = BLK_WORDS_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [15:0]                  i_addr,
  output logic                         i_grant,
  output logic                         i_fill_valid,
  output logic [$clog2(BLK_WORDS)-1:0] i_fill_idx,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [15:0]                  d_addr,
  input  logic [15:0]                  d_wdata,
  output logic                         d_grant,
  output logic                         d_fill_valid,
  output logic [$clog2(BLK_WORDS)-1:0] d_fill_idx,
  output logic                         d_done,
  output logic [15:0]                  fill_data,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [15:0]                  mem_addr,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata,
  input  logic                         mem_rvalid,
  output logic [1:0]                   dbg_state_o
);

  localparam int          IW       = $clog2(BLK_WORDS);
  localparam logic [15:0] BLK_MASK = 16'(BLK_WORDS * WORD_BYTES - 1);

  arb_state_e  state_q, state_d;
  logic [15:0] base_q, base_d;
  logic        last_d_q, last_d_d;

  logic          fill_active;
  logic          seq_issue_en;
  logic [15:0]   seq_offset;
  logic          seq_recv_en;
  logic [IW-1:0] seq_idx;
  logic          seq_last;

  assign fill_active = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
  assign dbg_state_o = state_q;

  mem_fill_seq #(
    .BLK_WORDS  (BLK_WORDS),
    .WORD_BYTES (WORD_BYTES)
  ) u_fill_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .active_i   (fill_active),
    .rvalid_i   (mem_rvalid),
    .issue_en_o (seq_issue_en),
    .offset_o   (seq_offset),
    .recv_en_o  (seq_recv_en),
    .fill_idx_o (seq_idx),
    .last_o     (seq_last)
  );

  // Next-state: arbitration in IDLE (alternating priority on a tie), return
  // to IDLE on the last fill word or after the single write cycle.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    last_d_d = last_d_q;
    unique case (state_q)
      ST_IDLE: begin
        if (d_req && (!i_req || !last_d_q)) begin
          base_d   = d_addr;
          last_d_d = 1'b1;
          state_d  = d_wr ? ST_D_WRITE : ST_D_FILL;
        end else if (i_req) begin
          base_d   = i_addr;
          last_d_d = 1'b0;
          state_d  = ST_I_FILL;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (seq_last) state_d = ST_IDLE;
      end
      ST_D_WRITE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode; everything is zero unless the current state drives it.
  always_comb begin
    i_grant      = (state_q == ST_I_FILL);
    d_grant      = (state_q == ST_D_FILL) || (state_q == ST_D_WRITE);
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_fill_idx   = '0;
    d_fill_idx   = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    fill_data    = '0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (state_q == ST_D_WRITE) begin
      // Writes use the live d_addr as given, without block alignment.
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      d_done    = 1'b1;
    end else if (fill_active) begin
      if (seq_issue_en) begin
        mem_en   = 1'b1;
        mem_addr = (base_q & ~BLK_MASK) + seq_offset;
      end
      if (seq_recv_en) begin
        fill_data = mem_rdata;
        if (state_q == ST_I_FILL) begin
          i_fill_valid = 1'b1;
          i_fill_idx   = seq_idx;
          i_done       = seq_last;
        end else begin
          d_fill_valid = 1'b1;
          d_fill_idx   = seq_idx;
          d_done       = seq_last;
        end
      end
    end
  end

  // State, latched base address and last-winner flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_d_q <= last_d_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_fill_valid, i_done;
  logic [2:0]  i_fill_idx, d_fill_idx;
  logic        d_grant, d_fill_valid, d_done;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_rvalid;
  logic [1:0]  dbg_state;
  logic        inj_rvalid;
  logic        mon_en;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_addr_q[$];
  logic [20:0] exp_fill_q[$];  // {side_d, last, idx[2:0], data}
  logic [31:0] exp_wr_q[$];    // {addr, data}

  logic [63:0] all_out;
  assign all_out = {i_grant, i_fill_valid, i_fill_idx, i_done, d_grant, d_fill_valid,
                    d_fill_idx, d_done, fill_data, mem_en, mem_wr, mem_addr, mem_wdata,
                    dbg_state};

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_fill_valid(i_fill_valid),
    .i_fill_idx(i_fill_idx), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
    .d_fill_valid(d_fill_valid), .d_fill_idx(d_fill_idx), .d_done(d_done),
    .fill_data(fill_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Memory model: reads return addr^5A5A exactly 4 cycles after issue.
  logic        pv[4];
  logic [15:0] pa[4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        pv[k] <= 1'b0;
        pa[k] <= '0;
      end
    end else begin
      pv[0] <= mem_en && !mem_wr;
      pa[0] <= mem_addr;
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
    end
  end
  assign mem_rvalid = pv[3] | inj_rvalid;
  assign mem_rdata  = pv[3] ? (pa[3] ^ 16'h5A5A) : (inj_rvalid ? 16'hDEAD : 16'h0000);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fill(input bit side_d, input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a = base + 16'(2 * k);
      exp_addr_q.push_back(a);
      exp_fill_q.push_back({side_d, (k == 7), 3'(k), a ^ 16'h5A5A});
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the done pulse of one side; returns at that negedge.
  task automatic wait_done(input bit side_d);
    int  n;
    logic got;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      got = side_d ? d_done : i_done;
    end while (!got && n < 200);
    chk(side_d ? "d_done_timeout" : "i_done_timeout", 64'(got), 64'd1);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (mem_en && mem_wr) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
        else begin
          chk("write_cmd", 64'({mem_addr, mem_wdata}), 64'(exp_wr_q.pop_front()));
          chk("write_done", 64'({d_done, i_done, d_grant}), 64'b101);
        end
      end else if (mem_en) begin
        chk("read_wdata_zero", 64'(mem_wdata), 64'd0);
        if (exp_addr_q.size() == 0) chk("unexpected_read", 64'(mem_addr), 64'hFFFF_FFFF);
        else chk("read_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (i_fill_valid || d_fill_valid) begin
        if (exp_fill_q.size() == 0) chk("unexpected_fill", 64'(fill_data), 64'hFFFF_FFFF);
        else begin
          logic [20:0] e;
          e = exp_fill_q.pop_front();
          chk("fill_word", 64'({d_fill_valid, (d_done | i_done),
                                d_fill_valid ? d_fill_idx : i_fill_idx, fill_data}), 64'(e));
          chk("fill_owner", 64'({d_fill_valid, i_fill_valid, d_done, i_done}),
              64'({e[20], !e[20], e[20] & e[19], !e[20] & e[19]}));
        end
      end else begin
        chk("quiet_fill_data", 64'(fill_data), 64'd0);
        if (!(mem_en && mem_wr)) chk("stray_done", 64'({i_done, d_done}), 64'd0);
      end
    end
  end

  typedef struct {
    bit          side_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_base;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h00F0};
    vecs[1] = '{1'b1, 1'b0, 16'hFFF1, 16'h0000, 16'hFFF0};
    vecs[2] = '{1'b1, 1'b1, 16'h1235, 16'h0A0B, 16'h1235};
    vecs[3] = '{1'b0, 1'b0, 16'h8000, 16'h0000, 16'h8000};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{1'b1, 1'b0, 16'h000F, 16'h0000, 16'h0000};

    rst_n = 1'b0; i_req = 0; d_req = 0; d_wr = 0; inj_rvalid = 0; mon_en = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    #2;
    chk("reset_outputs", all_out, 64'd0);
    step();
    rst_n = 1'b1;

    // Reset in the middle of a D fill (word 3 returning).
    d_req = 1; d_wr = 0; d_addr = 16'h2000;
    n = 0;
    do begin @(negedge clk); n++; end while (!(d_fill_valid && d_fill_idx == 3'd3) && n < 60);
    chk("reach_d_word3", 64'({d_fill_valid, d_fill_idx}), 64'({1'b1, 3'd3}));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_out, 64'd0);
    d_req = 0;
    step(); step();
    rst_n = 1'b1;
    mon_en = 1;

    // I fill at 0x1236; grant one cycle after req.
    push_fill(1'b0, 16'h1230);
    i_req = 1; i_addr = 16'h1236;
    @(negedge clk);
    chk("no_grant_same_cycle", 64'({i_grant, d_grant}), 64'd0);
    @(negedge clk);
    chk("i_grant_next_cycle", 64'({i_grant, d_grant}), 64'b10);
    wait_done(1'b0);
    step(); i_req = 0;

    // Tie after reset: D first, I in the IDLE cycle after d_done.
    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    push_fill(1'b1, 16'h4000);
    push_fill(1'b0, 16'h1100);
    i_req = 1; i_addr = 16'h1104; d_req = 1; d_wr = 0; d_addr = 16'h4008;
    d_wdata = 16'($urandom_range(0, 65535));
    @(negedge clk);
    @(negedge clk);
    chk("tie_d_first", 64'({i_grant, d_grant}), 64'b01);
    wait_done(1'b1);
    step(); d_req = 0;
    @(negedge clk);
    chk("idle_between", 64'({i_grant, d_grant, dbg_state}), 64'd0);
    @(negedge clk);
    chk("i_after_d", 64'({i_grant, d_grant}), 64'b10);
    wait_done(1'b0);
    step(); i_req = 0;

    // Fairness: D write wins (last winner was I), then I beats re-requesting D.
    push_wr(16'h0044, 16'hBEEF);
    push_fill(1'b0, 16'h3000);
    push_fill(1'b1, 16'h5000);
    i_req = 1; i_addr = 16'h3002; d_req = 1; d_wr = 1; d_addr = 16'h0044; d_wdata = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    chk("dwrite_cycle", 64'({i_grant, d_grant, mem_en, mem_wr, d_done}), 64'b01111);
    step(); d_wr = 0; d_addr = 16'h5004;
    @(negedge clk);
    chk("idle_after_write", 64'(dbg_state), 64'd0);
    @(negedge clk);
    chk("fair_i_wins", 64'({i_grant, d_grant}), 64'b10);
    wait_done(1'b0);
    step(); i_req = 0;
    wait_done(1'b1);
    step(); d_req = 0;

    // Robustness: address change after grant, req dropped at word 2.
    push_fill(1'b0, 16'h6000);
    i_req = 1; i_addr = 16'h600A;
    @(negedge clk);
    @(negedge clk);
    chk("robust_grant", 64'({i_grant, d_grant}), 64'b10);
    step(); i_addr = 16'h7777;
    n = 0;
    do begin @(negedge clk); n++; end while (!(i_fill_valid && i_fill_idx == 3'd2) && n < 60);
    chk("reach_i_word2", 64'({i_fill_valid, i_fill_idx}), 64'({1'b1, 3'd2}));
    step(); i_req = 0;
    wait_done(1'b0);
    step(); step();

    // Stray mem_rvalid while idle.
    inj_rvalid = 1;
    @(negedge clk);
    chk("inject_idle", 64'({i_fill_valid, d_fill_valid, i_done, d_done, fill_data, dbg_state}),
        64'd0);
    step(); inj_rvalid = 0;

    // Back-to-back I fills: exactly one IDLE cycle, new base.
    push_fill(1'b0, 16'h1200);
    i_req = 1; i_addr = 16'h120E;
    wait_done(1'b0);
    step(); i_addr = 16'h131F;
    push_fill(1'b0, 16'h1310);
    @(negedge clk);
    chk("b2b_idle", 64'({i_grant, dbg_state}), 64'd0);
    @(negedge clk);
    chk("b2b_regrant", 64'({i_grant, mem_en, mem_addr}), 64'({1'b1, 1'b1, 16'h1310}));
    wait_done(1'b0);
    step(); i_req = 0;

    // Table-driven single-side transactions.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].wr) push_wr(vecs[v].addr, vecs[v].wdata);
      else push_fill(vecs[v].side_d, vecs[v].exp_base);
      if (vecs[v].side_d) begin
        d_req = 1; d_wr = vecs[v].wr; d_addr = vecs[v].addr;
        d_wdata = vecs[v].wr ? vecs[v].wdata : 16'($urandom_range(1, 65535));
      end else begin
        i_req = 1; i_addr = vecs[v].addr;
      end
      wait_done(vecs[v].side_d);
      step(); i_req = 0; d_req = 0; d_wr = 0;
      @(negedge clk);
    end

    repeat (6) @(negedge clk);
    chk("queues_empty", 64'({exp_addr_q.size(), exp_fill_q.size()}) | 64'(exp_wr_q.size()),
        64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle, pipelined main memory between the instruction-cache miss handler (I side) and the data-cache miss/write-through handler (D side).
- Arbitrates between the two sides, sequences 8-word block fills by issuing consecutive word addresses, and counts returning words.
- Performs single-word data writes.
- Sits between both cache controllers and the memory model; the rest of the pipeline stalls on the cache controllers, not on this block.

Parameters:
- BLK_WORDS, 8: words per cache block; power of two, ≥2.
- WORD_BYTES, 2: bytes per word; block base = address with low log2(BLK_WORDS*WORD_BYTES) bits cleared.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- i_req  in  1  I-side fill request; held until i_done
- i_addr  in  16  I-side miss address (any byte in block)
- i_grant  out  1  I side owns memory
- i_fill_valid  out  1  fill word present on fill_data for I
- i_fill_idx  out  log2(BLK_WORDS)  word index of current I fill word
- i_done  out  1  one-cycle pulse, I transaction complete
- d_req  in  1  D-side request; held until d_done
- d_wr  in  1  1 = single-word write, 0 = block fill
- d_addr  in  16  D-side address
- d_wdata  in  16  D-side write data
- d_grant  out  1  D side owns memory
- d_fill_valid  out  1  fill word present for D
- d_fill_idx  out  log2(BLK_WORDS)  word index of current D fill word
- d_done  out  1  one-cycle pulse, D transaction complete
- fill_data  out  16  returned memory word (mem_rdata passthrough)
- mem_en  out  1  memory command valid
- mem_wr  out  1  memory write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid; arrives in order, fixed latency ≥1

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- Registers: base (16), issue_cnt and recv_cnt (0..BLK_WORDS), last_d (1).
- Reset (async, rst_n low): state=IDLE, counters=0, last_d=0, base=0. Every output is 0; fill_data is 0 when no *_fill_valid is asserted.
- Reset mid-transaction aborts it with no done pulse.
- IDLE, arbitration at each rising edge:
  - only d_req → D; only i_req → I.
  - both → I if last_d=1, else D.
  - winner's address is latched into base; last_d is set to 1 if D won, else 0.
  - D with d_wr=1 → D_WRITE; otherwise → the corresponding FILL state.
- Grants are decoded from state: i_grant=(state==I_FILL), d_grant=(state==D_FILL|D_WRITE).
- FILL states:
  - Issue: while issue_cnt<BLK_WORDS, drive mem_en=1, mem_wr=0, mem_addr = block-aligned base + issue_cnt*WORD_BYTES; issue_cnt increments each cycle. This gives exactly BLK_WORDS consecutive issue cycles starting in the first FILL cycle.
  - Receive: on mem_rvalid, owner's *_fill_valid=1, *_fill_idx=recv_cnt, fill_data=mem_rdata; recv_cnt increments. Issue and receive may overlap in the same cycle.
  - Completion: when mem_rvalid arrives with recv_cnt==BLK_WORDS-1, *_done=1 in that same cycle; next state IDLE, counters cleared.
- D_WRITE: lasts one cycle. mem_en=1, mem_wr=1, mem_addr=d_addr (unaligned, as given), mem_wdata=d_wdata, d_done=1; next state IDLE.
- Requester contract: deassert req at the edge ending the done cycle. A req still high in the following IDLE cycle is a new request.
- Dropping req mid-transaction is ignored; the transaction completes and done still pulses.
- Changes to i_addr/d_addr after grant are ignored; base is latched at grant.
- mem_rvalid outside a FILL state, or after recv_cnt reaches BLK_WORDS, is ignored: no outputs, no counter change.
- The first grant decision is made one cycle after req rises; the minimum fill is BLK_WORDS+latency cycles.
- mem_wdata=0 whenever mem_wr=0.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, I_FILL, D_FILL, D_WRITE);
  - BLK_WORDS and WORD_BYTES defaults;
  - derived IDX_W and OFFSET_W constants.
- Sub-module mem_fill_seq: owns issue_cnt/recv_cnt and generates address offset, issue enable, fill index and last-word detect. Instantiated once and shared by both FILL states.
- Arbitration and FSM stay in mem_arbiter.

Test Plan:
- Reset check: assert rst_n low during D_FILL word 3. All outputs go 0 immediately; after release, i_req alone gets i_grant one cycle later with recv_cnt starting at 0.
- I fill, 4-cycle memory model: i_req with i_addr=0x1236. mem_addr issues 0x1230,0x1232,…,0x123E on 8 consecutive cycles; i_fill_valid pulses with idx 0..7 and matching data; i_done coincides with idx 7.
- Tie after reset: i_req and d_req (d_wr=0, d_addr=0x4008) rise together. D is served first (mem_addr 0x4000..0x400E); I is granted in the IDLE cycle after d_done.
- Fairness: D write (d_addr=0x0044, d_wdata=0xBEEF) gives one cycle of mem_en=mem_wr=1, addr 0x0044, data 0xBEEF, with d_done. Both requests then pending → I wins because last_d=1.
- Robustness, three checks:
  - i_req dropped at fill word 2 → fill still completes with i_done;
  - mem_rvalid injected in IDLE → no fill_valid and counters unchanged;
  - i_addr changed mid-fill → addresses unchanged.
- Back-to-back I fills: i_req re-asserted the cycle after i_done. A new grant follows after exactly one IDLE cycle, with base from the new i_addr.
